// File: rtl/mac_result_accumulator.sv
// Accumulates NSAMP valid results from the ((x*a)+b)*c pipeline, then scales, narrows and holds the sum for a ready/valid consumer.
// Optional saturating narrow: define ACC_SAT_EN (default build wraps, sat tied low).
module mac_result_accumulator #(
   parameter int WLin     = 13,
   parameter int PIPE_LAT = 3,
   parameter int NSAMP    = 4,
   parameter int SHIFT    = 2,
   parameter int WLres    = 12
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    issue_valid,
   input  logic signed [WLin-1:0]  din,
   input  logic                    out_ready,
   output logic                    out_valid,
   output logic signed [WLres-1:0] out_data,
   output logic                    sat,
   output logic                    overrun
);
   localparam int WLacc = WLin + $clog2(NSAMP);
   localparam int CW    = $clog2(NSAMP);
   localparam logic signed [WLacc-1:0] RES_MAX = WLacc'((2 ** (WLres - 1)) - 1);
   localparam logic signed [WLacc-1:0] RES_MIN = ~RES_MAX;

   typedef enum logic {IDLE, ACC} state_t;

   state_t                    state;
   logic [PIPE_LAT-1:0]       vld_pipe;
   logic                      v_al;
   logic [CW-1:0]             cnt;
   logic signed [WLacc-1:0]   acc;
   logic signed [WLacc-1:0]   din_ext;
   logic signed [WLacc-1:0]   sum;
   logic signed [WLacc-1:0]   scaled;
   logic signed [WLres-1:0]   nar;
   logic                      sat_n;
   logic                      complete;

   // Tail of the issue delay line lines up with din
   assign v_al     = vld_pipe[PIPE_LAT-1];
   assign din_ext  = {{(WLacc - WLin){din[WLin-1]}}, din};
   assign sum      = acc + din_ext;
   assign scaled   = sum >>> SHIFT;
   assign complete = v_al && (state == ACC) && (cnt == CW'(NSAMP - 1));

   always_comb begin
      nar   = WLres'(scaled);
      sat_n = 1'b0;
`ifdef ACC_SAT_EN
      if (scaled > RES_MAX) begin
         nar   = RES_MAX[WLres-1:0];
         sat_n = 1'b1;
      end else if (scaled < RES_MIN) begin
         nar   = RES_MIN[WLres-1:0];
         sat_n = 1'b1;
      end
`endif
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         vld_pipe <= '0;
      end else begin
         vld_pipe[0] <= issue_valid;
         for (int i = 1; i < PIPE_LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= IDLE;
         cnt   <= '0;
         acc   <= '0;
      end else if (v_al) begin
         case (state)
            IDLE: begin
               acc   <= din_ext;
               cnt   <= CW'(1);
               state <= ACC;
            end
            ACC: begin
               if (complete) begin
                  acc   <= '0;
                  cnt   <= '0;
                  state <= IDLE;
               end else begin
                  acc <= sum;
                  cnt <= cnt + CW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Single holding register; a result that finds it occupied and not draining is lost
   always_ff @(posedge CLK) begin
      if (RST) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         sat       <= 1'b0;
         overrun   <= 1'b0;
      end else if (complete && (!out_valid || out_ready)) begin
         out_valid <= 1'b1;
         out_data  <= nar;
         sat       <= sat_n;
      end else if (complete) begin
         overrun <= 1'b1;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_mac_result_accumulator.sv
// Directed test of mac_result_accumulator with a behavioural 3-stage upstream delay feeding din.
module tb_mac_result_accumulator;
   logic               clk = 1'b0;
   logic               rst;
   logic               issue_valid;
   logic signed [12:0] x;
   logic signed [12:0] p1, p2, din;
   logic               out_ready;
   logic               out_valid;
   logic signed [11:0] out_data;
   logic               sat;
   logic               overrun;
   int                 n_vec = 0;
   int                 n_err = 0;

   always #5 clk = ~clk;

   // Upstream stand-in: value applied with issue shows up on din three edges later
   always @(posedge clk) begin
      p1  <= x;
      p2  <= p1;
      din <= p2;
   end

   mac_result_accumulator dut (
      .CLK(clk), .RST(rst), .issue_valid(issue_valid), .din(din),
      .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
      .sat(sat), .overrun(overrun)
   );

   task automatic chk(input string tag, input longint got, input longint exp);
      n_vec++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   // Issues four samples on consecutive edges; returns at the negedge after the last issue edge
   task automatic issue4(input int a, input int b, input int c, input int d);
      int v[4];
      v = '{a, b, c, d};
      for (int i = 0; i < 4; i++) begin
         issue_valid = 1'b1;
         x = 13'(v[i]);
         @(negedge clk);
      end
      issue_valid = 1'b0;
      x = '0;
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; issue_valid = 1'b0; x = '0; out_ready = 1'b1;
      tick(); tick();
      chk("rst_valid", out_valid, 0);
      chk("rst_data", out_data, 0);
      chk("rst_sat", sat, 0);
      chk("rst_overrun", overrun, 0);
      rst = 1'b0;
      tick();

      // Basic average
      issue4(100, 200, 300, 400);
      tick(); chk("avg_early1", out_valid, 0);
      tick(); chk("avg_early2", out_valid, 0);
      tick(); chk("avg_valid", out_valid, 1);
      chk("avg_data", $signed(out_data), 250);
      chk("avg_sat", sat, 0);
      tick(); chk("avg_drop", out_valid, 0);

      // Floor shift: -7 >>> 2 = -2
      issue4(-1, -1, -1, -4);
      tick(); tick(); tick();
      chk("floor_valid", out_valid, 1);
      chk("floor_data", $signed(out_data), -2);
      tick(); chk("floor_drop", out_valid, 0);

      // Positive overflow of the result width
      issue4(4095, 4095, 4095, 4095);
      tick(); tick(); tick();
      chk("satp_valid", out_valid, 1);
`ifdef ACC_SAT_EN
      chk("satp_data", $signed(out_data), 2047);
      chk("satp_sat", sat, 1);
`else
      chk("satp_data", $signed(out_data), -1);
      chk("satp_sat", sat, 0);
`endif
      tick();

      // Negative overflow of the result width
      issue4(-4096, -4096, -4096, -4096);
      tick(); tick(); tick();
      chk("satn_valid", out_valid, 1);
`ifdef ACC_SAT_EN
      chk("satn_data", $signed(out_data), -2048);
      chk("satn_sat", sat, 1);
`else
      chk("satn_data", $signed(out_data), 0);
      chk("satn_sat", sat, 0);
`endif
      tick();

      // Back-pressure: second result dropped, first held
      out_ready = 1'b0;
      issue4(10, 10, 10, 10);
      issue4(20, 20, 20, 20);
      tick(); tick(); tick();
      chk("bp_valid", out_valid, 1);
      chk("bp_data", $signed(out_data), 10);
      chk("bp_overrun", overrun, 1);
      tick();
      chk("bp_hold_data", $signed(out_data), 10);
      out_ready = 1'b1;
      tick();
      chk("bp_drained", out_valid, 0);
      chk("bp_overrun_sticky", overrun, 1);
      rst = 1'b1; tick(); rst = 1'b0;
      chk("bp_overrun_clr", overrun, 0);

      // Completion coincides with transfer of the held result
      out_ready = 1'b0;
      issue4(4, 4, 4, 4);
      issue4(8, 8, 8, 8);
      tick(); tick();
      chk("sim_held_valid", out_valid, 1);
      chk("sim_held_data", $signed(out_data), 4);
      out_ready = 1'b1;
      tick();
      chk("sim_valid", out_valid, 1);
      chk("sim_data", $signed(out_data), 8);
      chk("sim_overrun", overrun, 0);
      tick();
      chk("sim_drained", out_valid, 0);

      // Reset mid-accumulation with samples still in flight
      issue_valid = 1'b1; x = 13'sd1000; tick();
      tick();
      issue_valid = 1'b0; x = '0;
      rst = 1'b1; tick(); rst = 1'b0;
      issue4(8, 8, 8, 8);
      tick(); chk("rst_mid_early1", out_valid, 0);
      tick(); chk("rst_mid_early2", out_valid, 0);
      tick(); chk("rst_mid_valid", out_valid, 1);
      chk("rst_mid_data", $signed(out_data), 8);
      tick(); chk("rst_mid_single", out_valid, 0);
      tick(); tick(); tick();
      chk("rst_mid_no_extra", out_valid, 0);
      chk("rst_mid_overrun", overrun, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
